// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared constants and types for the arithmetic datapath blocks (the 8x8
// Wallace product block, the 16/8 sequential divider and future units).
//   DW   : dividend / quotient / product width
//   VW   : divisor / remainder / operand width
//   ITER : number of restoring iterations per division (one per quotient bit)
// ---------------------------------------------------------------------------
package arith_pkg;

  localparam int DW   = 16;
  localparam int VW   = 8;
  localparam int ITER = 16;

  // Sequencer states for multi-cycle arithmetic units
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arith_state_e;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   t       in  VW+1  shifted partial remainder with the next dividend bit
//   divisor in  VW    divisor
//   pr_next out VW+1  partial remainder after this step
//   q_bit   out 1     quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
  import arith_pkg::*;
(
  input  logic [VW:0]   t,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_next,
  output logic          q_bit
);

  logic [VW+1:0] diff;

  // Subtract in one extra bit so the top bit is a clean borrow: when it is
  // clear the divisor fits and the difference becomes the new remainder,
  // otherwise the remainder is restored to t.
  always_comb begin
    diff    = {1'b0, t} - {2'b00, divisor};
    q_bit   = ~diff[VW+1];
    pr_next = q_bit ? diff[VW:0] : t;
  end

endmodule

// File: rtl/divider_16x8_seq.sv
// ---------------------------------------------------------------------------
// divider_16x8_seq
// Sequential unsigned divider, 16-bit dividend by 8-bit divisor, restoring
// shift-subtract, one quotient bit per clock, fixed latency.
// Ports:
//   clk   in   1   rising-edge clock
//   rst   in   1   synchronous active-high reset
//   start in   1   request, only honoured in IDLE
//   a     in   DW  dividend, captured on an accepted start
//   b     in   VW  divisor, captured on an accepted start
//   q     out  DW  quotient (valid while ready, held until the next start)
//   r     out  VW  remainder (valid while ready, held until the next start)
//   ready out  1   one-cycle result-valid pulse
//   busy  out  1   high while an operation is in flight or completing
//   dz    out  1   the current result came from a zero divisor
// ---------------------------------------------------------------------------
module divider_16x8_seq
  import arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          ready,
  output logic          busy,
  output logic          dz
);

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  arith_state_e  state;
  logic [DW-1:0] shreg;
  logic [VW-1:0] divisor;
  logic [VW:0]   pr;
  logic [3:0]    cnt;
  logic [VW:0]   t;
  logic [VW:0]   pr_next;
  logic          q_bit;
  logic          unused_pr_msb;

  // The dividend bits leave the top of shreg while quotient bits enter at
  // the bottom, so after the last iteration shreg holds the quotient.
  assign t = {pr[VW-1:0], shreg[DW-1]};

  // pr's top bit never feeds the next step (t only takes pr[VW-1:0]); it is
  // kept so pr matches the full step result.
  assign unused_pr_msb = pr[VW];

  div_step u_step (
    .t       (t),
    .divisor (divisor),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // Sequencer and datapath registers. A zero divisor takes no special path:
  // every step "fits", giving an all-ones quotient and the low dividend bits
  // as the remainder, and dz flags it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      divisor <= '0;
      pr      <= '0;
      cnt     <= '0;
      dz      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= a;
            divisor <= b;
            pr      <= '0;
            cnt     <= '0;
            dz      <= (b == '0);
            state   <= BUSY;
          end
        end
        BUSY: begin
          shreg <= {shreg[DW-2:0], q_bit};
          pr    <= pr_next;
          cnt   <= cnt + 4'd1;
          if (cnt == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign q     = shreg;
  assign r     = pr[VW-1:0];
  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

endmodule
